spad_event_capture: RTL and testbench

SPAD_EVENT_CAPTURE -- requirements
Module: spad_event_capture

---
 rtl/spad_event_capture.sv | 177 +++++++++++++++++
 tb/tb_spad_event_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spad_event_capture.sv
// SPAD hit capture: opens one measurement window, timestamps up to MAX_HITS gated
// hits with their intensity, pulses rst_auto after each hit, then drains the records.
module spad_event_capture #(
  parameter int unsigned WIN_CYC  = 512,
  parameter int unsigned MAX_HITS = 3,
  parameter int unsigned CLR_CYC  = 2
) (
  input  logic        clk_250M,
  input  logic        rst,
  input  logic        meas_en,
  input  logic        trig,
  input  logic        time_gate,
  input  logic [15:0] spad_int,
  output logic        TDC_start,
  output logic        rst_auto,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_idx,
  output logic [8:0]  res_time,
  output logic [15:0] res_int,
  output logic        res_last,
  output logic        res_empty,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned TW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int unsigned CW = $clog2(MAX_HITS + 1);
  localparam int unsigned KW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [TW-1:0] WIN_LAST  = TW'(WIN_CYC - 1);
  localparam logic [CW-1:0] HITS_FULL = CW'(MAX_HITS);
  localparam logic [KW-1:0] CLR_LAST  = KW'(CLR_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, ARM, CLR, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      trig_sync_q, gate_sync_q;
  logic            gate_prev_q;
  logic [TW-1:0]   win_cnt_q, win_cnt_d;
  logic [CW-1:0]   stored_q, stored_d;
  logic [CW-1:0]   rd_idx_q, rd_idx_d;
  logic            ovf_q, ovf_d;
  logic            clr_act_q, clr_act_d;
  logic [KW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [TW-1:0]   time_mem_q [MAX_HITS];
  logic [15:0]     int_mem_q  [MAX_HITS];

  logic trig_s, gate_s, hit, win_end, drain_last, store_en, drain, empty;

  assign trig_s     = trig_sync_q[1];
  assign gate_s     = gate_sync_q[1];
  assign hit        = trig_s & gate_s & ~gate_prev_q;
  assign win_end    = (win_cnt_q == WIN_LAST);
  assign empty      = (stored_q == '0);
  assign drain_last = empty || ((rd_idx_q + CW'(1)) == stored_q);
  assign drain      = (state_q == DRAIN);

  always_ff @(posedge clk_250M or posedge rst) begin
    if (rst) begin
      trig_sync_q <= '0;
      gate_sync_q <= '0;
      gate_prev_q <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[0], trig};
      gate_sync_q <= {gate_sync_q[0], time_gate};
      gate_prev_q <= gate_sync_q[1];
    end
  end

  always_ff @(posedge clk_250M or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      stored_q  <= '0;
      rd_idx_q  <= '0;
      ovf_q     <= 1'b0;
      clr_act_q <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      stored_q  <= stored_d;
      rd_idx_q  <= rd_idx_d;
      ovf_q     <= ovf_d;
      clr_act_q <= clr_act_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk_250M or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_HITS; i++) begin
        time_mem_q[i] <= '0;
        int_mem_q[i]  <= '0;
      end
    end else if (store_en) begin
      time_mem_q[stored_q] <= win_cnt_q;
      int_mem_q[stored_q]  <= spad_int;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    stored_d  = stored_q;
    rd_idx_d  = rd_idx_q;
    ovf_d     = ovf_q;
    clr_act_d = clr_act_q;
    clr_cnt_d = clr_cnt_q;
    store_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (meas_en) state_d = START;
      end
      START: begin
        win_cnt_d = '0;
        stored_d  = '0;
        rd_idx_d  = '0;
        ovf_d     = 1'b0;
        clr_act_d = 1'b0;
        clr_cnt_d = '0;
        state_d   = ARM;
      end
      ARM: begin
        win_cnt_d = win_cnt_q + TW'(1);
        // Window end wins over a coincident hit, which is dropped silently.
        if (win_end) begin
          state_d = DRAIN;
        end else if (hit) begin
          if (stored_q != HITS_FULL) begin
            store_en = 1'b1;
            stored_d = stored_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          clr_act_d = 1'b0;
          clr_cnt_d = '0;
          state_d   = CLR;
        end
      end
      CLR: begin
        win_cnt_d = win_cnt_q + TW'(1);
        if (win_end) begin
          clr_act_d = 1'b0;
          state_d   = DRAIN;
        end else if (!clr_act_q) begin
          clr_cnt_d = '0;
          if (!gate_s) clr_act_d = 1'b1;
        end else if (clr_cnt_q == CLR_LAST) begin
          clr_act_d = 1'b0;
          state_d   = ARM;
        end else begin
          clr_cnt_d = clr_cnt_q + KW'(1);
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (drain_last) state_d = IDLE;
          else            rd_idx_d = rd_idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign TDC_start = (state_q == START);
  assign rst_auto  = (state_q == CLR) && clr_act_q;
  assign busy      = (state_q != IDLE);
  assign ovf       = ovf_q;
  assign res_valid = drain;
  assign res_empty = drain && empty;
  assign res_last  = drain && drain_last;
  assign res_idx   = drain ? 2'(rd_idx_q) : '0;
  assign res_time  = (drain && !empty) ? 9'(time_mem_q[rd_idx_q]) : '0;
  assign res_int   = (drain && !empty) ? int_mem_q[rd_idx_q] : '0;

endmodule

// File: tb/tb_spad_event_capture.sv
// Directed bench for spad_event_capture: table of whole-window scenarios plus a
// hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_spad_event_capture;

  localparam int WIN = 512;

  logic        clk_250M = 1'b0;
  logic        rst = 1'b1;
  logic        meas_en = 1'b0;
  logic        trig = 1'b0;
  logic        time_gate = 1'b0;
  logic [15:0] spad_int = '0;
  logic        res_ready = 1'b0;
  logic        TDC_start, rst_auto, res_valid, res_last, res_empty, busy, ovf;
  logic [1:0]  res_idx;
  logic [8:0]  res_time;
  logic [15:0] res_int;

  always #2 clk_250M = ~clk_250M;

  spad_event_capture #(.WIN_CYC(512), .MAX_HITS(3), .CLR_CYC(2)) dut (
    .clk_250M  (clk_250M),
    .rst       (rst),
    .meas_en   (meas_en),
    .trig      (trig),
    .time_gate (time_gate),
    .spad_int  (spad_int),
    .TDC_start (TDC_start),
    .rst_auto  (rst_auto),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_idx   (res_idx),
    .res_time  (res_time),
    .res_int   (res_int),
    .res_last  (res_last),
    .res_empty (res_empty),
    .busy      (busy),
    .ovf       (ovf)
  );

  typedef struct {
    string name;
    int    nhits;
    int    hpos[4];   // window cycle (win_cnt) at which trig/time_gate are raised
    int    hint[4];
    int    gw;        // time_gate width in cycles
    int    stall;     // cycles res_ready is held low at the start of DRAIN
    bit    extra;     // pulse meas_en during ARM and DRAIN
    int    nrec;
    bit    empty;
    int    etime[3];
    int    eint[3];
    bit    eovf;
    int    eclr;      // expected rst_auto pulses
  } scen_t;

  scen_t scen[6];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_window(input scen_t s);
    int tdc_cnt, npulse, gate_off, hi, nexp, bad_busy, gate_bad, quiet_bad;
    int starts[4];
    int lens[4];
    bit prev_ra;
    tdc_cnt = 0; npulse = 0; gate_off = -1; hi = 0; bad_busy = 0; gate_bad = 0;
    quiet_bad = 0; prev_ra = 1'b0;
    for (int j = 0; j < 4; j++) begin starts[j] = -1; lens[j] = 0; end
    res_ready = (s.stall == 0);

    @(negedge clk_250M); meas_en = 1'b1;
    @(negedge clk_250M); meas_en = 1'b0;
    check({s.name, "/tdc_start"}, 64'(TDC_start), 64'd1);
    tdc_cnt += int'(TDC_start);

    for (int k = 0; k < WIN; k++) begin
      @(negedge clk_250M);
      tdc_cnt += int'(TDC_start);
      if (!busy || res_valid) bad_busy++;
      if (rst_auto) begin
        if (!prev_ra) begin
          if (npulse < 4) starts[npulse] = k;
          npulse++;
        end
        if (npulse <= 4) lens[npulse-1]++;
        if (time_gate) gate_bad++;
        trig = 1'b0;
        spad_int = '0;
      end
      prev_ra = rst_auto;
      if (k == gate_off) time_gate = 1'b0;
      meas_en = s.extra && (k == 100);
      if (hi < s.nhits && k == s.hpos[hi]) begin
        trig = 1'b1;
        time_gate = 1'b1;
        spad_int = 16'(s.hint[hi]);
        gate_off = k + s.gw;
        hi++;
      end
    end
    meas_en = 1'b0;
    check({s.name, "/busy_in_window"}, 64'(bad_busy), 64'd0);
    check({s.name, "/clr_pulses"}, 64'(npulse), 64'(s.eclr));
    check({s.name, "/clr_gate_low"}, 64'(gate_bad), 64'd0);
    for (int j = 0; j < s.eclr && j < npulse && j < 4; j++) begin
      check({s.name, "/clr_start"}, 64'(starts[j]), 64'(s.hpos[j] + s.gw + 3));
      check({s.name, "/clr_len"}, 64'(lens[j]), 64'd2);
    end

    nexp = s.empty ? 1 : s.nrec;
    @(negedge clk_250M);
    for (int i = 0; i < s.stall; i++) begin
      check({s.name, "/stall_hold"},
            64'({res_valid, res_idx, res_time, res_int, res_last, res_empty}),
            64'({1'b1, 2'd0, 9'(s.etime[0]), 16'(s.eint[0]), nexp == 1, s.empty}));
      meas_en = s.extra && (i == 3);
      @(negedge clk_250M);
      tdc_cnt += int'(TDC_start);
    end
    meas_en = 1'b0;
    res_ready = 1'b1;
    for (int r = 0; r < nexp; r++) begin
      check({s.name, "/valid"}, 64'(res_valid), 64'd1);
      check({s.name, "/idx"}, 64'(res_idx), 64'(r));
      check({s.name, "/time"}, 64'(res_time), 64'(s.etime[r]));
      check({s.name, "/int"}, 64'(res_int), 64'(s.eint[r]));
      check({s.name, "/last"}, 64'(res_last), 64'(r == nexp - 1));
      check({s.name, "/empty"}, 64'(res_empty), 64'(s.empty));
      check({s.name, "/ovf"}, 64'(ovf), 64'(s.eovf));
      check({s.name, "/drain_no_clr"}, 64'({busy, rst_auto}), 64'b10);
      meas_en = s.extra && (r == 1);
      @(negedge clk_250M);
      tdc_cnt += int'(TDC_start);
    end
    meas_en = 1'b0;
    check({s.name, "/valid_after_last"}, 64'(res_valid), 64'd0);
    check({s.name, "/idle_busy"}, 64'(busy), 64'd0);
    trig = 1'b0; time_gate = 1'b0; spad_int = '0;
    repeat (3) begin
      @(negedge clk_250M);
      tdc_cnt += int'(TDC_start);
      if (busy || res_valid) quiet_bad++;
    end
    check({s.name, "/idle_quiet"}, 64'(quiet_bad), 64'd0);
    check({s.name, "/tdc_once"}, 64'(tdc_cnt), 64'd1);
  endtask

  initial begin
    int bad;
    scen[0] = '{"three_hits", 3, '{24, 130, 300, 0}, '{7, 9, 5, 0}, 1, 0, 1'b0,
                3, 1'b0, '{26, 132, 302}, '{7, 9, 5}, 1'b0, 3};
    scen[1] = '{"empty", 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, 0, 1'b0,
                1, 1'b1, '{0, 0, 0}, '{0, 0, 0}, 1'b0, 0};
    scen[2] = '{"four_hits", 4, '{24, 100, 200, 300}, '{3, 4, 6, 8}, 3, 0, 1'b0,
                3, 1'b0, '{26, 102, 202}, '{3, 4, 6}, 1'b1, 4};
    scen[3] = '{"stall_extra_meas", 3, '{24, 130, 300, 0}, '{7, 9, 5, 0}, 1, 10, 1'b1,
                3, 1'b0, '{26, 132, 302}, '{7, 9, 5}, 1'b0, 3};
    scen[4] = '{"window_end_hit", 4, '{24, 130, 300, 509}, '{65535, 2, 48879, 4660}, 1, 0, 1'b0,
                3, 1'b0, '{26, 132, 302}, '{65535, 2, 48879}, 1'b0, 3};
    scen[5] = '{"post_reset", 1, '{50, 0, 0, 0}, '{11, 0, 0, 0}, 1, 0, 1'b0,
                1, 1'b0, '{52, 0, 0}, '{11, 0, 0}, 1'b0, 1};

    rst = 1'b1;
    repeat (2) @(negedge clk_250M);
    meas_en = 1'b1;
    @(negedge clk_250M);
    meas_en = 1'b0;
    check("reset_outputs",
          64'({TDC_start, rst_auto, res_valid, busy, ovf, res_last, res_empty,
               res_idx, res_time, res_int}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_250M);
    check("idle_after_reset", 64'({busy, TDC_start}), 64'd0);

    for (int i = 0; i < 5; i++) run_window(scen[i]);

    // Reset mid-window after one stored hit.
    @(negedge clk_250M); meas_en = 1'b1;
    @(negedge clk_250M); meas_en = 1'b0;
    check("rstwin/tdc_start", 64'(TDC_start), 64'd1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_250M);
      if (rst_auto) begin trig = 1'b0; spad_int = '0; end
      if (k == 25) time_gate = 1'b0;
      if (k == 24) begin trig = 1'b1; time_gate = 1'b1; spad_int = 16'h0055; end
    end
    check("rstwin/busy_before", 64'(busy), 64'd1);
    #0.5 rst = 1'b1;
    #0.5 check("rstwin/outputs_async",
               64'({TDC_start, rst_auto, res_valid, busy, ovf, res_last, res_empty,
                    res_idx, res_time, res_int}), 64'd0);
    @(negedge clk_250M); meas_en = 1'b1;
    @(negedge clk_250M); meas_en = 1'b0;
    @(negedge clk_250M); rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk_250M);
      if (busy || TDC_start) bad++;
    end
    check("rstwin/meas_en_ignored", 64'(bad), 64'd0);
    run_window(scen[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
